// File: rtl/vga_scan_ctrl.sv
// VGA raster scan controller: pixel divider, h/v counters, sync/blank decode, line prefetch handshake.
// Optional sticky vblank interrupt is built when VGA_SCAN_IRQ_EN is defined.
`timescale 1ns/1ps
module vga_scan_ctrl #(
  parameter int   HACTIVE  = 640,
  parameter int   HFP      = 16,
  parameter int   HSYNC    = 96,
  parameter int   HBP      = 48,
  parameter int   VACTIVE  = 480,
  parameter int   VFP      = 10,
  parameter int   VSYNC    = 2,
  parameter int   VBP      = 33,
  parameter int   CLK_DIV  = 2,
  parameter logic SYNC_POL = 1'b0,
  localparam int  HTOTAL   = HACTIVE + HFP + HSYNC + HBP,
  localparam int  VTOTAL   = VACTIVE + VFP + VSYNC + VBP,
  localparam int  HW       = $clog2(HTOTAL),
  localparam int  VW       = $clog2(VTOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          irq_clr,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          VGA_CLK,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_n,
  output logic          VGA_SYNC_n,
  output logic          line_start,
  output logic [VW-1:0] line_y,
  output logic          swap,
  output logic [15:0]   frame_cnt,
  output logic          irq
);

  localparam int DW = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [HW-1:0] H_LAST   = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(HACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(HACTIVE + HFP);
  localparam logic [HW-1:0] HS_END   = HW'(HACTIVE + HFP + HSYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(VACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(VACTIVE + VFP);
  localparam logic [VW-1:0] VS_END   = VW'(VACTIVE + VFP + VSYNC - 1);

  logic [DW-1:0] div;
  logic          pt;
  logic          h_wrap;
  logic          v_last;
  logic [VW-1:0] nxt;
  logic          hs_act;
  logic          vs_act;

  assign pt     = en && (div == DIV_LAST);
  assign h_wrap = pt && (hcount == H_LAST);
  assign v_last = (vcount == V_LAST);
  assign nxt    = v_last ? {VW{1'b0}} : vcount + VW'(1);

  // Pixel divider and raster counters; disabling the scan parks everything at the origin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div    <= {DW{1'b0}};
      hcount <= {HW{1'b0}};
      vcount <= {VW{1'b0}};
    end else if (!en) begin
      div    <= {DW{1'b0}};
      hcount <= {HW{1'b0}};
      vcount <= {VW{1'b0}};
    end else begin
      div <= pt ? {DW{1'b0}} : div + DW'(1);
      if (pt) begin
        if (hcount == H_LAST) begin
          hcount <= {HW{1'b0}};
          vcount <= nxt;
        end else begin
          hcount <= hcount + HW'(1);
        end
      end
    end
  end

  // Bank select flips at each handover into an active line; frame counter bumps on vertical wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      swap      <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      if (h_wrap && (nxt < V_ACT)) begin
        swap <= ~swap;
      end
      if (h_wrap && v_last) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // Monitor-side decode taken straight from the counter registers.
  always_comb begin
    hs_act      = (hcount >= HS_BEG) && (hcount <= HS_END);
    vs_act      = (vcount >= VS_BEG) && (vcount <= VS_END);
    VGA_HS      = hs_act ? SYNC_POL : ~SYNC_POL;
    VGA_VS      = vs_act ? SYNC_POL : ~SYNC_POL;
    VGA_BLANK_n = (hcount < H_ACT) && (vcount < V_ACT) && en;
    VGA_SYNC_n  = 1'b0;
    VGA_CLK     = (div >= DIV_HALF);
  end

  // Counters sit at the origin during reset, so the pulse must be masked explicitly there.
  always_comb begin
    line_start = !reset && en && (hcount == {HW{1'b0}}) && (div == {DW{1'b0}}) && (nxt < V_ACT);
    line_y     = nxt;
  end

`ifdef VGA_SCAN_IRQ_EN
  logic irq_set;

  assign irq_set = h_wrap && (nxt == V_ACT);

  // Sticky vblank flag; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (irq_set) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`else
  logic unused_irq_clr;

  assign unused_irq_clr = irq_clr;
  assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl using a tiny raster; expectations come from an elapsed-time model.
`timescale 1ns/1ps
module tb_vga_scan_ctrl;

  localparam int HACT = 8, HFP = 2, HSY = 2, HBP = 2;
  localparam int VACT = 4, VFP = 1, VSY = 1, VBP = 1;
  localparam int HT = HACT + HFP + HSY + HBP;   // 14
  localparam int VT = VACT + VFP + VSY + VBP;   // 7
  localparam int LINE_CLK  = 2 * HT;            // 28
  localparam int FRAME_CLK = LINE_CLK * VT;     // 196

  logic        clk, reset, en, irq_clr;
  logic [3:0]  hcount;
  logic [2:0]  vcount, line_y;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;
  logic        line_start, swap, irq;
  logic [15:0] frame_cnt;

  vga_scan_ctrl #(
    .HACTIVE(HACT), .HFP(HFP), .HSYNC(HSY), .HBP(HBP),
    .VACTIVE(VACT), .VFP(VFP), .VSYNC(VSY), .VBP(VBP),
    .CLK_DIV(2), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .irq_clr(irq_clr),
    .hcount(hcount), .vcount(vcount),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_n(VGA_BLANK_n), .VGA_SYNC_n(VGA_SYNC_n),
    .line_start(line_start), .line_y(line_y), .swap(swap),
    .frame_cnt(frame_cnt), .irq(irq)
  );

  typedef struct {
    logic [3:0]  hcount;
    logic [2:0]  vcount;
    logic        hs, vs, blank, vclk, ls;
    logic [2:0]  ly;
    logic        swap;
    logic [15:0] fc;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state: clocks elapsed since the scan last left the origin.
  int          m_t    = 0;
  logic        m_swap = 1'b0;
  logic [15:0] m_fc   = 16'd0;
  logic        m_irq  = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model_out(input logic en_v, input logic rst_v);
    exp_t e;
    int d, h, v, nv;
    d = m_t % 2;
    h = (m_t / 2) % HT;
    v = (m_t / LINE_CLK) % VT;
    nv = (v + 1) % VT;
    e.hcount = 4'(h);
    e.vcount = 3'(v);
    e.hs     = !(h >= 10 && h <= 11);
    e.vs     = !(v == 5);
    e.blank  = en_v && (h < HACT) && (v < VACT);
    e.vclk   = (d == 1);
    e.ls     = en_v && !rst_v && (h == 0) && (d == 0) && (nv < VACT);
    e.ly     = 3'(nv);
    e.swap   = m_swap;
    e.fc     = m_fc;
    e.irq    = m_irq;
    return e;
  endfunction

  task automatic model_step(input logic en_v, input logic clr_v);
    int  nv;
    logic set;
    set = 1'b0;
    if (en_v) begin
      if (m_t % LINE_CLK == LINE_CLK - 1) begin
        nv = ((m_t + 1) / LINE_CLK) % VT;
        if (nv < VACT) m_swap = ~m_swap;
        if (nv == 0)   m_fc   = m_fc + 16'd1;
        set = (nv == VACT);
      end
      m_t++;
    end else begin
      m_t = 0;
    end
`ifdef VGA_SCAN_IRQ_EN
    if (set)        m_irq = 1'b1;
    else if (clr_v) m_irq = 1'b0;
`endif
  endtask

  task automatic compare_all(input exp_t e);
    check_value("hcount",      32'(hcount),      32'(e.hcount));
    check_value("vcount",      32'(vcount),      32'(e.vcount));
    check_value("VGA_HS",      32'(VGA_HS),      32'(e.hs));
    check_value("VGA_VS",      32'(VGA_VS),      32'(e.vs));
    check_value("VGA_BLANK_n", 32'(VGA_BLANK_n), 32'(e.blank));
    check_value("VGA_CLK",     32'(VGA_CLK),     32'(e.vclk));
    check_value("VGA_SYNC_n",  32'(VGA_SYNC_n),  32'd0);
    check_value("line_start",  32'(line_start),  32'(e.ls));
    if (e.ls) check_value("line_y", 32'(line_y), 32'(e.ly));
    check_value("swap",        32'(swap),        32'(e.swap));
    check_value("frame_cnt",   32'(frame_cnt),   32'(e.fc));
    check_value("irq",         32'(irq),         32'(e.irq));
  endtask

  // One clock: drive inputs, queue the post-edge expectation, then pop and compare.
  task automatic tick(input logic en_v, input logic clr_v);
    exp_t e;
    en      = en_v;
    irq_clr = clr_v;
    model_step(en_v, clr_v);
    sb.push_back(model_out(en_v, 1'b0));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compare_all(e);
  endtask

  task automatic model_reset();
    m_t    = 0;
    m_swap = 1'b0;
    m_fc   = 16'd0;
    m_irq  = 1'b0;
  endtask

  initial begin
    int   ls_cnt, sw_cnt, hs_cnt, vs_cnt, bl_cnt;
    logic prev_swap;

    reset   = 1'b1;
    en      = 1'b0;
    irq_clr = 1'b0;
    #2;
    compare_all(model_out(1'b0, 1'b1));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First frame, with a clear coinciding with the irq set and a later lone clear.
    for (int i = 0; i < FRAME_CLK; i++) begin
      tick(1'b1, (m_t == 4 * LINE_CLK - 1) || (m_t == 130));
    end
    check_value("frame_cnt_first_frame", 32'(frame_cnt), 32'd1);

    // Second frame: tally pulse and level occupancy over one full period.
    ls_cnt = 0; sw_cnt = 0; hs_cnt = 0; vs_cnt = 0; bl_cnt = 0;
    prev_swap = swap;
    for (int i = 0; i < FRAME_CLK; i++) begin
      tick(1'b1, 1'b0);
      if (line_start)   ls_cnt++;
      if (swap != prev_swap) sw_cnt++;
      prev_swap = swap;
      if (!VGA_HS)      hs_cnt++;
      if (!VGA_VS)      vs_cnt++;
      if (VGA_BLANK_n)  bl_cnt++;
    end
    check_value("line_start_per_frame", 32'(ls_cnt), 32'd4);
    check_value("swap_toggles_per_frame", 32'(sw_cnt), 32'd4);
    check_value("hs_low_clks_per_frame", 32'(hs_cnt), 32'd28);
    check_value("vs_low_clks_per_frame", 32'(vs_cnt), 32'd28);
    check_value("blank_n_clks_per_frame", 32'(bl_cnt), 32'd64);
    check_value("frame_cnt_two_frames", 32'(frame_cnt), 32'd2);

    // Walk to vcount 2, hcount 5, then pause and resume the scan.
    while (m_t % FRAME_CLK != 2 * LINE_CLK + 10) tick(1'b1, 1'b0);
    check_value("pause_point_h", 32'(hcount), 32'd5);
    check_value("pause_point_v", 32'(vcount), 32'd2);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    for (int i = 0; i < 100; i++) tick(1'b1, 1'b0);

    // Asynchronous reset mid-line, checked before any clock edge can occur.
    reset = 1'b1;
    model_reset();
    #1;
    compare_all(model_out(en, 1'b1));
    #1;
    reset = 1'b0;
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 Parameter HACTIVE, 640, active pixels per line.
REQ-002 Parameter HFP, 16, horizontal front porch, in pixels.
REQ-003 Parameter HSYNC, 96, horizontal sync width, in pixels.
REQ-004 Parameter HBP, 48, horizontal back porch, in pixels.
REQ-005 Parameter VACTIVE, 480, active lines per frame.
REQ-006 Parameter VFP, 10, vertical front porch, in lines.
REQ-007 Parameter VSYNC, 2, vertical sync width, in lines.
REQ-008 Parameter VBP, 33, vertical back porch, in lines.
REQ-009 Parameter CLK_DIV, 2, clk cycles per pixel; must be >=2.
REQ-010 Parameter SYNC_POL, 0, sync active level for both HS and VS (0 = active-low).
REQ-011 clk  in  1  system clock.
REQ-012 reset  in  1  asynchronous, active-high reset.
REQ-013 en  in  1  scan enable; low holds the scan idle.
REQ-014 irq_clr  in  1  single-cycle pulse that clears irq.
REQ-015 hcount  out  HW=$clog2(HTOTAL)  current pixel column; HTOTAL=HACTIVE+HFP+HSYNC+HBP.
REQ-016 vcount  out  VW=$clog2(VTOTAL)  current line; VTOTAL=VACTIVE+VFP+VSYNC+VBP.
REQ-017 VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n  out  1 each  DAC/monitor signals.
REQ-018 line_start  out  1  one-clk pulse that starts the line-prefetch engines.
REQ-019 line_y  out  VW  row to prefetch; valid while line_start is high.
REQ-020 swap  out  1  linebuffer bank select; toggles on each line handover.
REQ-021 frame_cnt  out  16  count of completed frames.
REQ-022 irq  out  1  sticky vblank interrupt.

Function
REQ-023 Divider div counts 0..CLK_DIV-1 while en=1; pixel tick pt = (div==CLK_DIV-1).
REQ-024 hcount SHALL increment on pt; on pt with hcount==HTOTAL-1, hcount SHALL wrap to 0 and vcount SHALL increment; vcount==VTOTAL-1 at that point SHALL wrap to 0.
REQ-025 Line order SHALL be active, front porch, sync, back porch; the vertical axis uses the same order.
REQ-026 HS SHALL be active for hcount in [HACTIVE+HFP, HACTIVE+HFP+HSYNC-1]; VS likewise on vcount; output level per SYNC_POL.
REQ-027 VGA_BLANK_n = (hcount<HACTIVE)&&(vcount<VACTIVE)&&en; VGA_SYNC_n SHALL be 0.
REQ-028 VGA_CLK SHALL be high when div>=CLK_DIV/2 (integer division).
REQ-029 All signals in REQ-026..028 SHALL be decoded from the counter registers with zero added latency.
REQ-030 nxt = (vcount==VTOTAL-1) ? 0 : vcount+1; line_start=1 for one clk when hcount==0 && div==0 && nxt<VACTIVE && en; line_y=nxt.
REQ-031 swap SHALL toggle on pt with hcount==HTOTAL-1 && nxt<VACTIVE.
REQ-032 frame_cnt SHALL increment, wrapping modulo 2^16, on the pt that wraps vcount to 0.
REQ-033 When en=0: div, hcount and vcount SHALL clear to 0 on the next clk; line_start=0; swap and frame_cnt hold; VGA_BLANK_n=0.

Reset
REQ-034 On reset assertion, with no clock edge required, div, hcount, vcount, swap, frame_cnt and irq SHALL be 0, line_start SHALL be 0, and HS/VS SHALL be at their inactive level.

Configuration
REQ-035 VGA_SCAN_IRQ_EN defined: irq SHALL set on the pt that enters vcount==VACTIVE with hcount==0; irq_clr SHALL clear it; set SHALL win over a simultaneous clear.
REQ-036 VGA_SCAN_IRQ_EN undefined: irq SHALL be tied to 0, irq_clr SHALL be ignored, and no irq flop SHALL exist.

Verification (bench params HACTIVE=8 HFP=2 HSYNC=2 HBP=2 VACTIVE=4 VFP=1 VSYNC=1 VBP=1 CLK_DIV=2 SYNC_POL=0)
REQ-037 Release reset, en=1 -> hcount wraps 13->0 every 28 clk; vcount wraps 6->0 every 196 clk; frame_cnt=1 at clk 196.
REQ-038 Scan full frame -> VGA_HS=0 exactly for hcount 10..11; VGA_VS=0 exactly for vcount 5; VGA_BLANK_n=1 only for hcount<8 && vcount<4; VGA_CLK period 2 clk.
REQ-039 Scan full frame -> line_start pulses at vcount 6,0,1,2 with line_y 0,1,2,3; none at vcount 3,4,5; swap toggles 4 times per frame.
REQ-040 IRQ_EN defined -> irq rises entering vcount 4; irq_clr pulse on that same clk -> irq stays 1; a later lone irq_clr -> irq=0. IRQ_EN undefined -> irq stays 0.
REQ-041 en=0 at vcount 2, hcount 5 -> counters 0 the next clk, line_start stays 0, swap unchanged; en=1 -> scan restarts at hcount 0, vcount 0.
REQ-042 Assert reset mid-line with no clock edge -> all outputs at their reset values immediately.
